seg_fault_sequencer: RTL

//   Sits directly downstream of the segment limit check at the AG/ME boundary and consumes its EXC output plus the TLB page-fault flag.
//   On a fault it kills the faulting instruction, freezes fetch, waits for older in-flight instructions to drain, pulses a pipeline flush, then redirects fetch to the handler.

---
 rtl/seg_fault_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_fault_sequencer.sv
// Segment/page fault sequencer at the AG/ME boundary.
// Kills the faulting instruction, drains older work, flushes the pipe,
// then redirects fetch to the fault handler. Faulting EIP/vector are
// latched for the microcode push sequence.
module seg_fault_sequencer #(
  parameter int          DRAIN_STAGES = 3,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] GP_HANDLER   = 32'h0000_1000,
  parameter logic [31:0] PF_HANDLER   = 32'h0000_2000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LIMIT_EXC,
  input  logic                    PF_EXC,
  input  logic [31:0]             EIP_AG,
  input  logic [DRAIN_STAGES-1:0] OLDER_V,
  input  logic                    BR_FLUSH_IN,
  input  logic                    FETCH_ACK,
  output logic                    KILL_AG,
  output logic                    HOLD_FETCH,
  output logic                    FLUSH,
  output logic                    REDIRECT_V,
  output logic [31:0]             REDIRECT_EIP,
  output logic [31:0]             FAULT_EIP,
  output logic [7:0]              FAULT_VEC
);

  localparam logic [7:0] VEC_GP   = 8'h0D;
  localparam logic [7:0] VEC_PF   = 8'h0E;
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_redirect_eip;
  logic [31:0] r_fault_eip;
  logic [7:0]  r_fault_vec;

  logic        w_fault;
  logic        w_capture;
  logic [7:0]  w_vec;
  logic [31:0] w_handler;

  // Limit violation takes priority over a page fault on the same instruction.
  assign w_fault   = LIMIT_EXC | PF_EXC;
  assign w_vec     = LIMIT_EXC ? VEC_GP : VEC_PF;
  assign w_handler = LIMIT_EXC ? GP_HANDLER : PF_HANDLER;

  // State, flush counter and fault capture registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_redirect_eip <= 32'd0;
      r_fault_eip    <= 32'd0;
      r_fault_vec    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_redirect_eip <= w_handler;
        r_fault_eip    <= EIP_AG;
        r_fault_vec    <= w_vec;
      end
    end
  end

  // Next-state, counter and control-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    KILL_AG     = 1'b0;
    HOLD_FETCH  = 1'b0;
    FLUSH       = 1'b0;
    REDIRECT_V  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A fault younger than a mispredicted branch dies with the branch flush.
        if (w_fault && !BR_FLUSH_IN) begin
          KILL_AG     = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        KILL_AG    = 1'b1;
        HOLD_FETCH = 1'b1;
        if (BR_FLUSH_IN) begin
          w_state_nxt = S_IDLE;
        end else if (OLDER_V == '0) begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Nothing older remains, so a branch flush cannot arrive meaningfully here.
        KILL_AG    = 1'b1;
        HOLD_FETCH = 1'b1;
        FLUSH      = 1'b1;
        w_cnt_nxt  = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        KILL_AG    = 1'b1;
        HOLD_FETCH = 1'b1;
        REDIRECT_V = 1'b1;
        if (FETCH_ACK) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign REDIRECT_EIP = r_redirect_eip;
  assign FAULT_EIP    = r_fault_eip;
  assign FAULT_VEC    = r_fault_vec;

endmodule
